// File: rtl/gaus_cordic_arb_if.sv
// rtl/gaus_cordic_arb_if.sv - requester and result bundle of the shared cordic arbiter
interface gaus_cordic_arb_if #(
  parameter int pN    = 4,
  parameter int pID_W = 2
);
  logic [pN-1:0]    ireq;
  logic [pN*11-1:0] iphase;
  logic [pN-1:0]    oack;
  logic             oval;
  logic [pID_W-1:0] oid;
  logic [17:0]      ocos;
  logic [17:0]      osin;

  modport master (output ireq, iphase, input oack, oval, oid, ocos, osin);
  modport slave  (input ireq, iphase, output oack, oval, oid, ocos, osin);
endinterface

// File: rtl/gaus_cordic_arb.sv
// rtl/gaus_cordic_arb.sv - round-robin sharing of one 5-stage phase->cos/sin unit between pN requesters

// Phase -> cos/sin with a quarter-wave cosine ROM, 5 enabled clocks of latency.
// Full scale A = 131071. Outputs are not reset; a valid tag travels alongside.
module gaus_cordic (
  input  logic        iclk,
  input  logic        iclkena,
  input  logic [10:0] iphase,
  output logic [17:0] ocos,
  output logic [17:0] osin
);
  localparam longint cA = 131071;

  // round(A * cos(idx * (pi/2) / 512)), Taylor series evaluated in Q30 at elaboration
  function automatic logic [16:0] qcos(input int idx);
    longint x, x2, term, acc;
    x    = (longint'(idx) * 64'sd1686629713) / 512;
    x2   = (x * x) >>> 30;
    term = 64'sd1 <<< 30;
    acc  = term;
    for (int k = 1; k <= 7; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
      acc  = acc + term;
    end
    if (acc < 0) acc = 0;
    return 17'((cA * acc + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [16:0] w_rom [0:512];
  for (genvar g = 0; g <= 512; g++) begin : g_rom
    localparam logic [16:0] cV = qcos(g);
    assign w_rom[g] = cV;
  end

  logic [10:0]        r_ph;
  logic [1:0]         r_q;
  logic [16:0]        r_ca, r_cb;
  logic [9:0]         w_ia, w_ib;
  logic signed [17:0] w_pa, w_pb, w_cos, w_sin;
  logic signed [17:0] r_cos [0:2];
  logic signed [17:0] r_sin [0:2];

  // in-quadrant offset r reads cos(r) and cos(90deg - r) = sin(r)
  assign w_ia = {1'b0, r_ph[8:0]};
  assign w_ib = 10'd512 - w_ia;
  assign w_pa = signed'({1'b0, r_ca});
  assign w_pb = signed'({1'b0, r_cb});

  // quadrant folding: rotate the first-quadrant pair by q * 90 degrees
  always_comb begin
    w_cos = w_pa;
    w_sin = w_pb;
    unique case (r_q)
      2'd0: begin w_cos = w_pa;  w_sin = w_pb;  end
      2'd1: begin w_cos = -w_pb; w_sin = w_pa;  end
      2'd2: begin w_cos = -w_pa; w_sin = -w_pb; end
      2'd3: begin w_cos = w_pb;  w_sin = -w_pa; end
    endcase
  end

  // phase reg, ROM read, sign apply, two delay stages: 5 enabled clocks
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      r_ph     <= iphase;
      r_q      <= r_ph[10:9];
      r_ca     <= w_rom[w_ia];
      r_cb     <= w_rom[w_ib];
      r_cos[0] <= w_cos;
      r_sin[0] <= w_sin;
      r_cos[1] <= r_cos[0];
      r_sin[1] <= r_sin[0];
      r_cos[2] <= r_cos[1];
      r_sin[2] <= r_sin[1];
    end
  end

  assign ocos = r_cos[2];
  assign osin = r_sin[2];
endmodule

// pLAT must equal the gaus_cordic latency (5); the tag pipe mirrors it.
module gaus_cordic_arb #(
  parameter int pN    = 4,
  parameter int pID_W = 2,
  parameter int pLAT  = 5
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  gaus_cordic_arb_if.slave  bus
);
  logic [pID_W-1:0] r_ptr;
  logic [pID_W-1:0] w_idx;
  logic [pID_W-1:0] w_gid;
  logic             w_found;
  logic             w_grant;
  logic [10:0]      w_phase;
  logic [pLAT-1:0]  r_val;
  logic [pID_W-1:0] r_id [pLAT];

  // search ptr+1, ptr+2, ... mod pN for the first requester
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    for (int i = 1; i <= pN; i++) begin
      w_idx = pID_W'((int'(r_ptr) + i) % pN);
      if (!w_found && bus.ireq[w_idx]) begin
        w_found = 1'b1;
        w_gid   = w_idx;
      end
    end
  end

  assign w_grant  = iclkena & w_found;
  assign bus.oack = w_grant ? ({{(pN-1){1'b0}}, 1'b1} << w_gid) : '0;
  // idle slots feed phase 0; their tag carries val=0 so the result is dropped
  assign w_phase  = w_grant ? bus.iphase[int'(w_gid) * 11 +: 11] : 11'd0;

  // round-robin pointer and {val,id} tag pipe, both frozen while iclkena=0
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_ptr <= pID_W'(pN - 1);
      r_val <= '0;
      for (int i = 0; i < pLAT; i++) r_id[i] <= '0;
    end else if (iclkena) begin
      if (w_grant) r_ptr <= w_gid;
      r_val   <= {r_val[pLAT-2:0], w_grant};
      r_id[0] <= w_gid;
      for (int i = 1; i < pLAT; i++) r_id[i] <= r_id[i-1];
    end
  end

  assign bus.oval = r_val[pLAT-1];
  assign bus.oid  = r_id[pLAT-1];

  gaus_cordic u_cordic (
    .iclk    (iclk),
    .iclkena (iclkena),
    .iphase  (w_phase),
    .ocos    (bus.ocos),
    .osin    (bus.osin)
  );
endmodule
